// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin access controller for a 16x4 synchronous RAM
//
// Purpose: shares one RAM port between two valid/ready requesters. At most one
// command is issued per cycle, and read data is steered back to the requester
// that owns it. Read latency is 3 cycles from transfer to response.
// Optional feature macro: RAM_ARB_CLEAR_EN (zero-fill pass after reset, busy high).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   reqN_valid/wr/addr/wdata request from requester N (N = 0, 1)
//   reqN_ready               grant, combinational from the arbitration
//   rspN_valid/rdata         one-cycle read response pulse, registered data
//   ram_en/wr/addr/indata    registered RAM command
//   ram_outdata              RAM read data, valid the cycle after a read is sampled
//   busy                     high while the clear pass is running

module ram_arbiter #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_wr,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_wr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_indata,
    input  logic [DW-1:0] ram_outdata,
    output logic          busy
);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

`ifdef RAM_ARB_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_RUN;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          prio_q, prio_d;      // 1 = requester 1 wins the next tie
    logic          ram_en_q, ram_en_d;
    logic          ram_wr_q, ram_wr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_indata_q, ram_indata_d;
    // Owner tag pipeline: stage 1 = command on the RAM pins, stage 2 = data on ram_outdata.
    logic          p1_valid_q, p1_valid_d;
    logic          p1_owner_q, p1_owner_d;
    logic          p2_valid_q, p2_valid_d;
    logic          p2_owner_q, p2_owner_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic          run;
    logic          gnt0, gnt1;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        // Gating with rst keeps the readies low as soon as reset asserts.
        run       = rst && (state_q == S_RUN);
        gnt0      = run && req0_valid && (!req1_valid || !prio_q);
        gnt1      = run && req1_valid && (!req0_valid ||  prio_q);
        sel_wr    = gnt1 ? req1_wr    : req0_wr;
        sel_addr  = gnt1 ? req1_addr  : req0_addr;
        sel_wdata = gnt1 ? req1_wdata : req0_wdata;

        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        prio_d       = prio_q;
        ram_en_d     = 1'b0;
        ram_wr_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_indata_d = ram_indata_q;

        if (state_q == S_CLEAR) begin
            ram_en_d     = 1'b1;
            ram_wr_d     = 1'b1;
            ram_addr_d   = clr_cnt_q;
            ram_indata_d = '0;
            clr_cnt_d    = clr_cnt_q + AW'(1);
            if (clr_cnt_q == {AW{1'b1}}) begin
                state_d = S_RUN;
            end
        end else if (gnt0 || gnt1) begin
            ram_en_d     = 1'b1;
            ram_wr_d     = sel_wr;
            ram_addr_d   = sel_addr;
            ram_indata_d = sel_wdata;
            prio_d       = gnt0;            // the other requester wins the next tie
        end

        p1_valid_d   = (gnt0 || gnt1) && !sel_wr;
        p1_owner_d   = gnt1;
        p2_valid_d   = p1_valid_q;
        p2_owner_d   = p1_owner_q;
        rsp0_valid_d = p2_valid_q && !p2_owner_q;
        rsp1_valid_d = p2_valid_q &&  p2_owner_q;
        rsp0_rdata_d = rsp0_valid_d ? ram_outdata : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_valid_d ? ram_outdata : rsp1_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= '0;
            prio_q       <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_indata_q <= '0;
            p1_valid_q   <= 1'b0;
            p1_owner_q   <= 1'b0;
            p2_valid_q   <= 1'b0;
            p2_owner_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            prio_q       <= prio_d;
            ram_en_q     <= ram_en_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_indata_q <= ram_indata_d;
            p1_valid_q   <= p1_valid_d;
            p1_owner_q   <= p1_owner_d;
            p2_valid_q   <= p2_valid_d;
            p2_owner_q   <= p2_owner_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign ram_en     = ram_en_q;
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_indata = ram_indata_q;

`ifdef RAM_ARB_CLEAR_EN
    assign busy = rst && (state_q == S_CLEAR);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural RAM and reference model

module tb_ram_arbiter;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef RAM_ARB_CLEAR_EN
    localparam int CLR_CYCLES = DEPTH;
`else
    localparam int CLR_CYCLES = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid, req0_wr, req1_valid, req1_wr;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_indata;
    logic [DW-1:0] ram_outdata;
    logic          busy;

    always #5 clk = ~clk;

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_indata(ram_indata), .ram_outdata(ram_outdata), .busy(busy)
    );

    // Behavioural 16x4 synchronous RAM (not reset).
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        ram_outdata <= '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_indata;
            else        ram_outdata   <= mem[ram_addr];
        end
    end

    // Reference model state
    typedef struct {
        int            cyc;
        bit            port;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          rq[$];
    logic [DW-1:0] mmem [DEPTH];
    int            cyc;
    bit            m_prio;
    int            clear_left;
    bit            e_en, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] l0, l1;
    bit            last_g0, last_g1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set0(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = v; req0_wr = w; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = v; req1_wr = w; req1_addr = a; req1_wdata = d;
    endtask

    task automatic check_zero(input string tag);
        check(tag, int'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
                         ram_en, ram_wr, ram_addr, ram_indata, busy}), 0);
    endtask

    // Hold reset for n cycles with both valids high, then release; called at posedge+1.
    task automatic do_reset(input int n);
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_zero("reset_immediate");
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(posedge clk);
        #1;
        rq.delete();
        m_prio     = 1'b0;
        clear_left = CLR_CYCLES;
        e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
        l0 = '0; l1 = '0;
        last_g0 = 1'b0; last_g1 = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
    endtask

    // One clock cycle: check outputs at negedge against the model, advance the model.
    task automatic tick();
        bit run, g0, g1, ev0, ev1;
        @(negedge clk);
        run = (clear_left == 0);
        g0 = 1'b0; g1 = 1'b0;
        if (run) begin
            if (req0_valid && req1_valid) begin
                if (m_prio) g1 = 1'b1; else g0 = 1'b1;
            end else if (req0_valid) g0 = 1'b1;
            else if (req1_valid)     g1 = 1'b1;
        end
        check("req0_ready", int'(req0_ready), int'(g0));
        check("req1_ready", int'(req1_ready), int'(g1));
        check("busy", int'(busy), int'(!run));
        check("ram_en", int'(ram_en), int'(e_en));
        check("ram_wr", int'(ram_wr), int'(e_wr));
        check("ram_addr", int'(ram_addr), int'(e_addr));
        check("ram_indata", int'(ram_indata), int'(e_data));
        ev0 = 1'b0; ev1 = 1'b0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            if (rq[0].port) begin ev1 = 1'b1; l1 = rq[0].data; end
            else            begin ev0 = 1'b1; l0 = rq[0].data; end
            void'(rq.pop_front());
        end
        check("rsp0_valid", int'(rsp0_valid), int'(ev0));
        check("rsp1_valid", int'(rsp1_valid), int'(ev1));
        check("rsp0_rdata", int'(rsp0_rdata), int'(l0));
        check("rsp1_rdata", int'(rsp1_rdata), int'(l1));

        if (!run) begin
            e_en = 1'b1; e_wr = 1'b1;
            e_addr = AW'(DEPTH - clear_left);
            e_data = '0;
            mmem[e_addr] = '0;
            clear_left--;
        end else if (g0 || g1) begin
            e_en   = 1'b1;
            e_wr   = g1 ? req1_wr    : req0_wr;
            e_addr = g1 ? req1_addr  : req0_addr;
            e_data = g1 ? req1_wdata : req0_wdata;
            if (e_wr) mmem[e_addr] = e_data;
            else      rq.push_back('{cyc + 3, g1, mmem[e_addr]});
            m_prio = g0;
        end else begin
            e_en = 1'b0; e_wr = 1'b0;
        end
        last_g0 = g0;
        last_g1 = g1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, n1, k;
        cyc = 0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        @(posedge clk);
        #1;
        do_reset(3);
        repeat (CLR_CYCLES + 1) tick();

        // Write 1010 to addr 3 via req0, then read it via req1
        set0(1, 1, 4'd3, 4'b1010); tick();
        set0(0, 0, '0, '0);
        set1(1, 0, 4'd3, '0);      tick();
        set1(0, 0, '0, '0);
        repeat (4) tick();
        check("wr_rd_rsp1_data", int'(rsp1_rdata), 10);

        // Contention: both requesters write 4 addresses each
        n0 = 0; n1 = 0; k = 0;
        while ((n0 < 4 || n1 < 4) && k < 20) begin
            set0(n0 < 4, 1, AW'(n0), DW'($urandom));
            set1(n1 < 4, 1, AW'(8 + n1), DW'($urandom));
            tick();
            if (last_g0) n0++;
            if (last_g1) n1++;
            k++;
        end
        check("contention_n0", n0, 4);
        check("contention_n1", n1, 4);
        check("contention_cycles", k, 8);
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        tick();

        // Streaming: fill descending pattern then read back-to-back
        for (int i = 0; i < DEPTH; i++) begin
            set0(1, 1, AW'(i), DW'(15 - i)); tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            set0(1, 0, AW'(i), '0); tick();
        end
        set0(0, 0, '0, '0);
        repeat (4) tick();
        check("stream_last_data", int'(rsp0_rdata), 0);

        // Preload addr 5, reset, then read it back
        set0(1, 1, 4'd5, 4'b0101); tick();
        set0(0, 0, '0, '0);        tick();
        do_reset(2);
        set0(1, 0, 4'd5, '0);
        k = 0;
        last_g0 = 1'b0;
        while (!last_g0 && k < 40) begin
            tick();
            k++;
        end
        check("clear_read_granted", int'(last_g0), 1);
        check("clear_grant_wait", k, CLR_CYCLES + 1);
        set0(0, 0, '0, '0);
        repeat (4) tick();
        check("addr5_after_reset", int'(rsp0_rdata), (CLR_CYCLES != 0) ? 0 : 5);

        // Reset part-way through (restarts any clear pass)
        do_reset(1);
        repeat (5) tick();
        do_reset(1);
        repeat (CLR_CYCLES + 4) tick();

        // Reset with two reads in flight: no responses afterwards
        set0(1, 0, 4'd2, '0); tick();
        set0(1, 0, 4'd7, '0); tick();
        do_reset(2);
        set0(0, 0, '0, '0);
        repeat (CLR_CYCLES + 8) tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                set0($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
                set1($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
                tick();
            end
        end
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
